// File: rtl/cordic_nco_frontend.sv
// Phase-generation front end for the pipelined CORDIC rotator: an NCO with a
// double-buffered tuning word, continuous/burst sequencing and an output-valid delay line.
module cordic_nco_frontend #(
  parameter int XYWIDTH = 16,
  parameter int ZWIDTH  = 32,
  parameter int STAGE   = 16,
  parameter int BLW     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               en,
  input  logic               start,
  input  logic [BLW-1:0]     burst_len,
  input  logic [ZWIDTH-1:0]  ftw_in,
  input  logic               ftw_ld,
  input  logic [ZWIDTH-1:0]  pow_in,
  input  logic               phase_clr,
  input  logic [XYWIDTH-1:0] amp_in,
  output logic [ZWIDTH-1:0]  z0,
  output logic [XYWIDTH-1:0] x0,
  output logic [XYWIDTH-1:0] y0,
  output logic               z_valid,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BURST, S_FLUSH} state_t;

  state_t             state, state_nxt;
  logic [ZWIDTH-1:0]  acc, ftw_act, ftw_shd, ftw_eff;
  logic               pend;
  logic [BLW-1:0]     cnt;
  logic               from_burst;
  logic [STAGE-1:0]   dly;
  logic               active, issue_ok, tick, drained, done_nxt;

  assign active   = (state == S_RUN) || (state == S_BURST);
  // RUN stops issuing in the same cycle en is sampled low.
  assign issue_ok = ((state == S_RUN) && en) || (state == S_BURST);
  assign tick     = ce && issue_ok && !phase_clr;
  // The sample issued on the FLUSH entry edge is still in z_valid, not yet in dly.
  assign drained  = (dly == '0) && !z_valid;
  assign ftw_eff  = ftw_ld ? ftw_in : (pend ? ftw_shd : ftw_act);

  assign out_valid = dly[STAGE-1];

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (en)         state_nxt = S_RUN;
        else if (start) state_nxt = S_BURST;
      end
      S_RUN:   if (!en) state_nxt = S_FLUSH;
      S_BURST: if (tick && (cnt == BLW'(1))) state_nxt = S_FLUSH;
      S_FLUSH: begin
        if (drained) begin
          state_nxt = S_IDLE;
          done_nxt  = from_burst;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      from_burst <= 1'b0;
    end else if (state == S_IDLE) begin
      if (en) begin
        from_burst <= 1'b0;
      end else if (start) begin
        cnt        <= (burst_len == '0) ? BLW'(1) : burst_len;
        from_burst <= 1'b1;
      end
    end else if ((state == S_BURST) && tick) begin
      cnt <= cnt - BLW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      ftw_act <= '0;
      ftw_shd <= '0;
      pend    <= 1'b0;
      z0      <= '0;
      x0      <= '0;
      y0      <= '0;
      z_valid <= 1'b0;
      dly     <= '0;
    end else begin
      z_valid <= tick;
      dly     <= {dly[STAGE-2:0], z_valid};

      if (tick) begin
        z0 <= acc + pow_in;
        x0 <= amp_in;
        y0 <= '0;
      end

      if (phase_clr)  acc <= '0;
      else if (tick)  acc <= acc + ftw_eff;

      // Outside RUN/BURST there is no sample to align to, so a new word takes effect at once.
      if (!active) begin
        if (ftw_ld) begin
          ftw_act <= ftw_in;
          ftw_shd <= ftw_in;
          pend    <= 1'b0;
        end
      end else if (tick) begin
        ftw_act <= ftw_eff;
        pend    <= 1'b0;
        if (ftw_ld) ftw_shd <= ftw_in;
      end else if (ftw_ld) begin
        ftw_shd <= ftw_in;
        pend    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_nco_frontend.sv
// Scoreboard bench for cordic_nco_frontend: directed stimulus pushes hand-computed
// operands; a negedge monitor pops them on z_valid and tracks out_valid/done.
module tb_cordic_nco_frontend;

  localparam int XYWIDTH = 16;
  localparam int ZWIDTH  = 32;
  localparam int STAGE   = 16;
  localparam int BLW     = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ce, en, start, ftw_ld, phase_clr;
  logic [BLW-1:0]     burst_len;
  logic [ZWIDTH-1:0]  ftw_in, pow_in;
  logic [XYWIDTH-1:0] amp_in;
  logic [ZWIDTH-1:0]  z0;
  logic [XYWIDTH-1:0] x0, y0;
  logic               z_valid, out_valid, busy, done;

  typedef struct packed {
    logic [ZWIDTH-1:0]  z;
    logic [XYWIDTH-1:0] x;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int done_cnt = 0;
  logic [STAGE-1:0]  hist;
  logic [ZWIDTH-1:0] last_z;
  int d0, o0;

  cordic_nco_frontend #(
    .XYWIDTH(XYWIDTH), .ZWIDTH(ZWIDTH), .STAGE(STAGE), .BLW(BLW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .en(en), .start(start),
    .burst_len(burst_len), .ftw_in(ftw_in), .ftw_ld(ftw_ld), .pow_in(pow_in),
    .phase_clr(phase_clr), .amp_in(amp_in), .z0(z0), .x0(x0), .y0(y0),
    .z_valid(z_valid), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ZWIDTH-1:0] z, input logic [XYWIDTH-1:0] x);
    exp_t e;
    e.z = z;
    e.x = x;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Monitor: scoreboard pop, z0 hold, out_valid latency against the observed z_valid history.
  always @(negedge clk) begin
    if (!rst_n) begin
      hist   = '0;
      last_z = '0;
    end else begin
      if (z_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_z_valid", z_valid, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("z0", z0, e_mon.z);
          check("x0", x0, e_mon.x);
          check("y0", y0, 0);
          last_z = e_mon.z;
        end
      end else begin
        check("z0_hold", z0, last_z);
      end
      if (out_valid || hist[STAGE-1]) check("out_valid_latency", out_valid, hist[STAGE-1]);
      hist = {hist[STAGE-2:0], z_valid};
      if (out_valid) ov_cnt++;
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ce = 1'b0; en = 1'b0; start = 1'b0; ftw_ld = 1'b0; phase_clr = 1'b0;
    burst_len = '0; ftw_in = '0; pow_in = '0; amp_in = 16'd19898;
    repeat (2) cyc();
    check("rst_z0", z0, 0);
    check("rst_x0", x0, 0);
    check("rst_zv", z_valid, 0);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    cyc();

    // Quarter-turn steps with wrap.
    ftw_in = 32'h4000_0000; ftw_ld = 1'b1;
    cyc();
    ftw_ld = 1'b0;
    d0 = done_cnt; o0 = ov_cnt;
    push(32'h0000_0000, 16'd19898);
    push(32'h4000_0000, 16'd19898);
    push(32'h8000_0000, 16'd19898);
    push(32'hC000_0000, 16'd19898);
    push(32'h0000_0000, 16'd19898);
    en = 1'b1; ce = 1'b1;
    cyc();
    check("run_busy", busy, 1);
    repeat (5) cyc();
    en = 1'b0;
    wait_idle();
    check("run_ov_count", ov_cnt - o0, 5);
    check("run_no_done", done_cnt - d0, 0);
    check("run_queue", exp_q.size(), 0);

    // Sparse ce, mid-run tuning word changes, and phase clear.
    ce = 1'b0; phase_clr = 1'b1; pow_in = 32'h2000_0000;
    ftw_in = 32'h0100_0000; ftw_ld = 1'b1;
    cyc();
    phase_clr = 1'b0; ftw_ld = 1'b0; en = 1'b1;
    cyc();
    push(32'h2000_0000, 16'd19898);
    push(32'h2100_0000, 16'd19898);
    push(32'h2200_0000, 16'd19898);
    repeat (3) begin
      ce = 1'b1; cyc();
      ce = 1'b0; cyc(); cyc();
    end
    ftw_in = 32'h0200_0000; ftw_ld = 1'b1;
    cyc();
    ftw_ld = 1'b0;
    push(32'h2300_0000, 16'd19898);
    push(32'h2500_0000, 16'd19898);
    ce = 1'b1; cyc();
    ce = 1'b0; cyc(); cyc();
    ce = 1'b1; cyc();
    ce = 1'b0; cyc();
    push(32'h2700_0000, 16'd19898);
    push(32'h2A00_0000, 16'd19898);
    ftw_in = 32'h0300_0000; ftw_ld = 1'b1; ce = 1'b1;
    cyc();
    ftw_ld = 1'b0; ce = 1'b0;
    check("bypass_pend", dut.pend, 0);
    cyc();
    ce = 1'b1; cyc();
    ce = 1'b0; cyc();
    phase_clr = 1'b1; ce = 1'b1;
    cyc();
    check("clr_suppress", z_valid, 0);
    phase_clr = 1'b0;
    push(32'h2000_0000, 16'd19898);
    push(32'h2300_0000, 16'd19898);
    cyc(); cyc();
    ce = 1'b0; en = 1'b0;
    wait_idle();
    check("sparse_queue", exp_q.size(), 0);

    // Burst of 3, with start held into BURST (must be ignored).
    phase_clr = 1'b1; ftw_in = 32'h1000_0000; ftw_ld = 1'b1; pow_in = '0; amp_in = 16'hEC78;
    cyc();
    phase_clr = 1'b0; ftw_ld = 1'b0;
    d0 = done_cnt; o0 = ov_cnt;
    push(32'h0000_0000, 16'hEC78);
    push(32'h1000_0000, 16'hEC78);
    push(32'h2000_0000, 16'hEC78);
    burst_len = 16'd3; start = 1'b1; ce = 1'b1;
    cyc();
    check("burst_busy", busy, 1);
    cyc();
    start = 1'b0;
    repeat (19) cyc();
    check("burst_pre_done", done, 0);
    check("burst_pre_busy", busy, 1);
    check("burst_ov_fallen", out_valid, 0);
    cyc();
    check("burst_done", done, 1);
    check("burst_busy_drop", busy, 0);
    cyc();
    check("burst_done_pulse", done, 0);
    check("burst_ov_count", ov_cnt - o0, 3);
    check("burst_done_count", done_cnt - d0, 1);
    check("burst_queue", exp_q.size(), 0);

    // burst_len = 0 issues one sample.
    d0 = done_cnt; o0 = ov_cnt;
    push(32'h3000_0000, 16'hEC78);
    burst_len = '0; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_idle();
    cyc();
    check("len0_ov_count", ov_cnt - o0, 1);
    check("len0_done_count", done_cnt - d0, 1);
    check("len0_queue", exp_q.size(), 0);

    // Reset after the 2nd sample of a 5-sample burst.
    amp_in = 16'd19898; d0 = done_cnt;
    phase_clr = 1'b1; burst_len = 16'd5; start = 1'b1; ce = 1'b0;
    cyc();
    phase_clr = 1'b0; start = 1'b0; ce = 1'b1;
    push(32'h0000_0000, 16'd19898);
    push(32'h1000_0000, 16'd19898);
    cyc(); cyc();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_z0", z0, 0);
    check("mid_rst_x0", x0, 0);
    check("mid_rst_zv", z_valid, 0);
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    ce = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_queue", exp_q.size(), 0);

    d0 = done_cnt; o0 = ov_cnt;
    ftw_in = 32'h0800_0000; ftw_ld = 1'b1; pow_in = 32'h0100_0000;
    burst_len = 16'd5; start = 1'b1;
    cyc();
    start = 1'b0; ftw_ld = 1'b0; ce = 1'b1;
    push(32'h0100_0000, 16'd19898);
    push(32'h0900_0000, 16'd19898);
    push(32'h1100_0000, 16'd19898);
    push(32'h1900_0000, 16'd19898);
    push(32'h2100_0000, 16'd19898);
    wait_idle();
    cyc();
    check("post_rst_ov_count", ov_cnt - o0, 5);
    check("post_rst_done_count", done_cnt - d0, 1);
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_nco_frontend.md
Name: cordic_nco_frontend

Overview:
- Phase-generation front end that sits directly upstream of the pipelined CORDIC rotator. It produces the z0/x0/y0 operands that the rotator consumes.
- Contains a ZWIDTH-bit phase accumulator (NCO) with a double-buffered frequency tuning word, a phase offset, phase clear, and sample-enable gating.
- Runs in continuous or fixed-length burst mode.
- Delays its issue strobe by the rotator latency, so out_valid lines up with the rotator's xout_r/yout_r.

Parameters:
- XYWIDTH, 16, width of x0/y0 operands and amplitude.
- ZWIDTH, 32, phase width; full scale = 2*pi, two's complement, top 2 bits = quadrant.
- STAGE, 16, rotator pipeline depth; the valid delay line is STAGE registers long.
- BLW, 16, width of the burst length counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  sample tick; one phase sample is issued per ce cycle while active.
- en  in  1  continuous-mode enable (level).
- start  in  1  burst start pulse; ignored unless state is IDLE.
- burst_len  in  BLW  number of samples per burst; 0 is treated as 1.
- ftw_in  in  ZWIDTH  frequency tuning word, unsigned.
- ftw_ld  in  1  write strobe: ftw_in goes to the shadow register.
- pow_in  in  ZWIDTH  phase offset word, added combinationally at issue.
- phase_clr  in  1  synchronous accumulator clear.
- amp_in  in  XYWIDTH  signed amplitude; pre-scale it by the CORDIC gain (default usage 19898).
- z0  out  ZWIDTH  phase operand to the rotator.
- x0  out  XYWIDTH  x operand (= latched amp).
- y0  out  XYWIDTH  y operand (always 0).
- z_valid  out  1  operands updated this cycle.
- out_valid  out  1  rotator output valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, rst_n=0): acc=0, ftw_act=0, ftw_shd=0, pend=0, z0=0, x0=0, y0=0, z_valid=0, delay line all 0, state=IDLE, cnt=0, busy=0, done=0.
- States:
  - IDLE
    - en=1 -> RUN.
    - start=1 and en=0 -> BURST, cnt=max(burst_len,1).
    - en has priority over start.
  - RUN: en=0 -> FLUSH. No issue happens in the cycle en is sampled low.
  - BURST: each issue decrements cnt; the issue with cnt=1 -> FLUSH. en is ignored.
  - FLUSH: the delay line drains with no issues. When all STAGE delay bits are 0 -> IDLE, with done=1 for one cycle only if entered from BURST.
- Issue condition: tick = ce & (state==RUN | state==BURST) & !phase_clr. On a tick, registered at the clock edge:
  - z0 <= acc + pow_in (mod 2^ZWIDTH).
  - acc <= acc + ftw_eff.
  - x0 <= amp_in; y0 <= 0; z_valid <= 1.
  - Otherwise z_valid <= 0 and z0/x0/y0 hold.
- First sample phase equals acc before any increment, so after a reset or clear the first z0 is pow_in.
- FTW double buffer:
  - ftw_ld writes ftw_shd and sets pend.
  - On the next tick, ftw_act <= ftw_shd and pend clears. The increment on that tick already uses the new word (ftw_eff = pend ? ftw_shd : ftw_act).
  - Simultaneous ftw_ld and tick: ftw_eff = ftw_in (bypass), ftw_act <= ftw_in, pend stays 0.
  - In IDLE and FLUSH, ftw_ld applies to ftw_act immediately, with no pending.
- phase_clr: acc <= 0 in any state. It suppresses the issue that cycle (z_valid=0) and does not affect cnt or pending FTW.
- Arithmetic: all phase sums are wrap-around modulo 2^ZWIDTH; no saturation.
- Latency:
  - z_valid asserted after edge j means the rotator samples at edge j+1, and out_valid is asserted after edge j+STAGE.
  - Delay line: d[0] <= z_valid, d[k] <= d[k-1], out_valid = d[STAGE-1]. The delay line shifts every cycle in every state.
- busy = (state != IDLE); registered from the next state.
- Burst length: start with burst_len=N produces exactly N z_valid pulses, on the first N ce ticks after entry. done fires the cycle after the last out_valid falls.
- start while busy: ignored.
- Reset mid-burst: all state clears immediately. No done pulse; out_valid drops asynchronously.

Test Plan:
- Reset, ftw_ld 0x40000000 in IDLE, pow_in=0, en=1, ce=1 -> z0 = 0x00000000, 0x40000000, 0x80000000, 0xC0000000, 0x00000000 (wrap). out_valid first high 16 cycles after the first z_valid.
- RUN with ftw 0x01000000, pow_in=0x20000000, ce asserted every 3rd cycle -> z_valid only on ce cycles; z0 steps 0x20000000, 0x21000000, 0x22000000; z0 holds between ticks.
- Mid-run ftw_ld 0x02000000 one cycle before a tick -> the increment on that tick uses 0x02000000. Repeat with ftw_ld coincident with the tick -> same result, and pend stays 0.
- phase_clr coincident with ce in RUN -> no z_valid that cycle; next tick z0 = pow_in.
- start, burst_len=3, ce=1, en=0 -> exactly 3 z_valid, then FLUSH. out_valid high for 3 cycles. done pulses once the cycle after the last out_valid; busy drops with it. burst_len=0 -> 1 sample.
- Assert rst_n=0 after the 2nd sample of a burst_len=5 burst -> all outputs 0 immediately, no done. A new start after release runs a clean 5-sample burst.
